// File: rtl/uart_rx_fifo_pkg.sv
// uart_rx_fifo_pkg
// Shared constants and types for the UART receive FIFO slice.
//   FIFO_DEPTH_LOG2_DEF / FIFO_RTS_THRESH_DEF : default depth and RTS threshold
//   byte_t                                    : one received UART byte
// Optional build macro used by this slice: UART_RX_FIFO_RTS_EN
//   defined   -> uart_rx_fifo has a registered rts_n flow-control output
//   undefined -> no rts_n port and RTS_THRESH is only range-checked
package uart_rx_fifo_pkg;

  localparam int FIFO_DEPTH_LOG2_DEF = 4;
  localparam int FIFO_RTS_THRESH_DEF = 12;
  localparam int DATA_W              = 8;

  typedef logic [DATA_W-1:0] byte_t;

  // Number of entries for a given log2 depth.
  function automatic int depth_of(input int log2);
    return 1 << log2;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if
// Byte path into and out of the receive FIFO.
//   rcv/din     : one-cycle strobe + byte from the serial receiver
//   dout/valid  : head-of-queue byte offered to the consumer
//   ready       : consumer takes dout this cycle
// master = receiver + consumer side, slave = the FIFO.
interface uart_rx_fifo_if;
  import uart_rx_fifo_pkg::*;

  logic  rcv;
  byte_t din;
  byte_t dout;
  logic  valid;
  logic  ready;

  modport master (output rcv, din, ready, input dout, valid);
  modport slave  (input rcv, din, ready, output dout, valid);

endinterface

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem
// Simple dual-port byte array: synchronous write, asynchronous read by
// address. Kept separate so it can be swapped for a BRAM-backed variant.
//   clk   : write clock
//   we    : write enable
//   waddr : write address,  wdata : write byte
//   raddr : read address,   rdata : byte at raddr (combinational)
// The array is not reset.
module uart_fifo_mem
  import uart_rx_fifo_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  byte_t             wdata,
  input  logic [ADDR_W-1:0] raddr,
  output byte_t             rdata
);

  byte_t mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Receive-side byte FIFO behind the UART receiver. Captures every byte
// strobed by rcv, offers the oldest byte on a show-ahead valid/ready port,
// and reports occupancy plus a sticky overflow flag.
//   clk, rstn      : clock, synchronous active-low reset
//   bus (slave)    : rcv/din in, dout/valid out, ready in
//   level          : occupancy 0..2**DEPTH_LOG2
//   full, empty    : decoded from level
//   overflow       : sticky, set when a byte is dropped on a full FIFO
//   ovf_clr        : clears overflow (a same-cycle drop wins)
//   rts_n          : only with UART_RX_FIFO_RTS_EN; high = stop sender
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = FIFO_DEPTH_LOG2_DEF,
  parameter int RTS_THRESH = FIFO_RTS_THRESH_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  uart_rx_fifo_if.slave     bus,
  output logic [DEPTH_LOG2:0] level,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  input  logic              ovf_clr
`ifdef UART_RX_FIFO_RTS_EN
  ,
  output logic              rts_n
`endif
);

  localparam int LVL_W = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [LVL_W-1:0]      LVL_ONE    = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [LVL_W-1:0]      LVL_ZERO   = {LVL_W{1'b0}};
  localparam logic [LVL_W-1:0]      LVL_FULL   = LVL_W'(depth_of(DEPTH_LOG2));
  localparam logic [LVL_W-1:0]      LVL_RTS    = LVL_W'(RTS_THRESH);

  // Elaboration-time guard on the parameter ranges.
  if (DEPTH_LOG2 < 2 || DEPTH_LOG2 > 8 || RTS_THRESH >= depth_of(DEPTH_LOG2))
  begin : g_bad_param
    $error("uart_rx_fifo: DEPTH_LOG2 must be 2..8 and RTS_THRESH < depth");
  end

  logic [DEPTH_LOG2-1:0] wr_ptr_reg, wr_ptr_next;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg, rd_ptr_next;
  logic [LVL_W-1:0]      level_reg,  level_next;
  logic                  overflow_reg, overflow_next;
  logic                  push, pop, drop;
  byte_t                 rd_data;

  assign full  = (level_reg == LVL_FULL);
  assign empty = (level_reg == LVL_ZERO);
  assign level    = level_reg;
  assign overflow = overflow_reg;

  assign bus.valid = ~empty;
  assign bus.dout  = rd_data;

  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign pop  = bus.valid & bus.ready;
  assign push = bus.rcv & (~full | pop);
  assign drop = bus.rcv & ~push;

  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    level_next    = level_reg;
    overflow_next = overflow_reg;

    if (push) wr_ptr_next = wr_ptr_reg + PTR_ONE;
    if (pop)  rd_ptr_next = rd_ptr_reg + PTR_ONE;

    case ({push, pop})
      2'b10:   level_next = level_reg + LVL_ONE;
      2'b01:   level_next = level_reg - LVL_ONE;
      default: level_next = level_reg;
    endcase

    // A fresh drop must never be hidden by a simultaneous clear.
    if (drop)         overflow_next = 1'b1;
    else if (ovf_clr) overflow_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      level_reg    <= level_next;
      overflow_reg <= overflow_next;
    end
  end

`ifdef UART_RX_FIFO_RTS_EN
  // Registered from the next-state level so it tracks the level register.
  logic rts_n_reg;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rts_n_reg <= 1'b0;
    end else begin
      rts_n_reg <= (level_next >= LVL_RTS);
    end
  end

  assign rts_n = rts_n_reg;
`else
  logic unused_rts;
  assign unused_rts = ^LVL_RTS;
`endif

  uart_fifo_mem #(
    .ADDR_W (DEPTH_LOG2)
  ) u_mem (
    .clk   (clk),
    .we    (push & rstn),
    .waddr (wr_ptr_reg),
    .wdata (bus.din),
    .raddr (rd_ptr_reg),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
// Directed scenarios plus randomized traffic against a queue-based model
// of the receive FIFO. One line per push/pop/drop/reset transaction.
module tb_uart_rx_fifo;
  import uart_rx_fifo_pkg::*;

  localparam int DL2   = 4;
  localparam int DEPTH = 16;
  localparam int RTS   = 12;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           ovf_clr = 1'b0;
  logic [DL2:0]   level;
  logic           full, empty, overflow;
`ifdef UART_RX_FIFO_RTS_EN
  logic           rts_n;
`endif

  uart_rx_fifo_if bus ();

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .DEPTH_LOG2 (DL2),
    .RTS_THRESH (RTS)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .bus      (bus),
    .level    (level),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
`ifdef UART_RX_FIFO_RTS_EN
    ,
    .rts_n    (rts_n)
`endif
  );

  int    total = 0;
  int    bad   = 0;
  byte_t q[$];
  bit    ovf_m = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare after it.
  task automatic step(input bit r, input byte_t d, input bit rdy, input bit clr, input bit rs);
    bit    pop, push, was_full;
    byte_t head;
    bus.rcv   = r;
    bus.din   = d;
    bus.ready = rdy;
    ovf_clr   = clr;
    rstn      = rs;
    @(posedge clk);
    if (!rs) begin
      q.delete();
      ovf_m = 1'b0;
      $display("reset");
    end else begin
      was_full = (q.size() == DEPTH);
      pop      = rdy && (q.size() > 0);
      push     = r && (!was_full || pop);
      if (pop) begin
        head = q.pop_front();
        $display("pop  %02h", head);
      end
      if (push) begin
        q.push_back(d);
        $display("push %02h", d);
      end
      if (r && !push) begin
        ovf_m = 1'b1;
        $display("drop %02h", d);
      end else if (clr) begin
        ovf_m = 1'b0;
      end
    end
    #1;
    check("level", 32'(level), 32'(q.size()));
    check("valid", 32'(bus.valid), 32'(q.size() != 0));
    check("empty", 32'(empty), 32'(q.size() == 0));
    check("full", 32'(full), 32'(q.size() == DEPTH));
    check("overflow", 32'(overflow), 32'(ovf_m));
    if (q.size() != 0) check("dout", 32'(bus.dout), 32'(q[0]));
`ifdef UART_RX_FIFO_RTS_EN
    check("rts_n", 32'(rts_n), 32'(q.size() >= RTS));
`endif
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic push_b(input byte_t d);
    step(1'b1, d, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic pop_b();
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    // Reset state
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_valid", 32'(bus.valid), 32'd0);

    // 1: three bytes, then drain in order
    push_b(8'h41); push_b(8'h42); push_b(8'h43);
    check("t1_level", 32'(level), 32'd3);
    check("t1_dout", 32'(bus.dout), 32'h41);
    for (int i = 0; i < 3; i++) begin
      check("t1_order", 32'(bus.dout), 32'(8'h41 + i));
      pop_b();
    end
    check("t1_empty", 32'(empty), 32'd1);

    // 2: fill, overflow drop, drain, clear
    for (int i = 0; i < DEPTH; i++) push_b(byte_t'(i));
    check("t2_full", 32'(full), 32'd1);
    push_b(8'hAA);
    check("t2_ovf", 32'(overflow), 32'd1);
    check("t2_level", 32'(level), 32'd16);
    for (int i = 0; i < DEPTH; i++) begin
      check("t2_order", 32'(bus.dout), 32'(i));
      pop_b();
    end
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    check("t2_ovf_clr", 32'(overflow), 32'd0);

    // 3: full with simultaneous push and pop
    for (int i = 0; i < DEPTH; i++) push_b(byte_t'(8'h10 + i));
    step(1'b1, 8'h55, 1'b1, 1'b0, 1'b1);
    check("t3_level", 32'(level), 32'd16);
    check("t3_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < DEPTH - 1; i++) pop_b();
    check("t3_last", 32'(bus.dout), 32'h55);
    pop_b();

    // 4: rcv+ready on empty, then pointer wrap
    step(1'b1, 8'h99, 1'b1, 1'b0, 1'b1);
    check("t4_valid", 32'(bus.valid), 32'd1);
    check("t4_dout", 32'(bus.dout), 32'h99);
    pop_b();
    for (int i = 0; i < 40; i++) begin
      push_b(byte_t'($urandom));
      check("t4_lvl1", 32'(level), 32'd1);
      pop_b();
    end

    // 5: reset with traffic present
    for (int i = 0; i < 5; i++) push_b(byte_t'(8'hC0 + i));
    push_b(8'hEE); // stays within depth, no overflow
    step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    check("t5_level", 32'(level), 32'd0);
    check("t5_valid", 32'(bus.valid), 32'd0);
    idle();
    check("t5_still_empty", 32'(empty), 32'd1);

    // Randomized traffic with varying consumer speed
    for (int phase = 0; phase < 3; phase++) begin
      int rdy_pct;
      rdy_pct = (phase == 0) ? 10 : (phase == 1) ? 50 : 90;
      for (int i = 0; i < 800; i++) begin
        step($urandom_range(99, 0) < 55,
             byte_t'($urandom),
             $urandom_range(99, 0) < rdy_pct,
             $urandom_range(99, 0) < 5,
             $urandom_range(199, 0) != 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
